// File: rtl/uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
// Optional even-parity build: define FIFO_UART_TX_PARITY_EN.
package uart_pkg;

    localparam int DATA_BITS   = 8;
    localparam int BYTES_CNT_W = 16;

    // PARITY keeps its encoding in every build so state values never shift.
    typedef enum logic [2:0] {
        IDLE,
        POP,
        LATCH,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1, flags the last cycle of each bit,
// and is realigned to 0 by restart_in so frame timing carries no baud jitter.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 868,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic restart_in,
    output logic bit_done_out
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt <= '0;
        end else if (restart_in || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign bit_done_out = (cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO read-side consumer: pops one byte at a time and serializes it as UART 8N1.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit (8E1 framing).
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter  int CLKS_PER_BIT = 868,
    localparam int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic                   enable_in,
    input  logic                   fifo_empty_in,
    input  logic [DATA_BITS-1:0]   fifo_data_in,
    output logic                   fifo_rd_en_out,
    output logic                   tx_out,
    output logic                   busy_out,
    output logic [BYTES_CNT_W-1:0] bytes_sent_out
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    tx_state_t            state, state_d;
    logic [DATA_BITS-1:0] shreg, shreg_d;
    logic [2:0]           bit_idx, bit_idx_d;
    logic                 bit_done;
    logic                 restart;
    logic                 tx_d, rd_en_d, busy_d;

`ifdef FIFO_UART_TX_PARITY_EN
    logic parity_q;
`endif

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_bit_timer (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .restart_in   (restart),
        .bit_done_out (bit_done)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (enable_in && !fifo_empty_in) state_d = POP;
            POP:     state_d = LATCH;
            LATCH:   state_d = START;
            START:   if (bit_done) state_d = DATA;
`ifdef FIFO_UART_TX_PARITY_EN
            DATA:    if (bit_done && bit_idx == LAST_BIT) state_d = PARITY;
            PARITY:  if (bit_done) state_d = STOP;
`else
            DATA:    if (bit_done && bit_idx == LAST_BIT) state_d = STOP;
`endif
            STOP:    if (bit_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from the next state and registered, so the line
    // changes exactly on bit boundaries with no input-to-output paths.
    always_comb begin
        shreg_d   = shreg;
        bit_idx_d = bit_idx;
        if (state == LATCH) begin
            shreg_d   = fifo_data_in;
            bit_idx_d = '0;
        end else if (state == DATA && bit_done) begin
            shreg_d   = shreg >> 1;
            bit_idx_d = bit_idx + 3'd1;
        end

        restart = (state == LATCH);
        rd_en_d = (state_d == POP);
        busy_d  = (state_d != IDLE);

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY:  tx_d = parity_q;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    // NOTE: the shift register is a handful of flops, not a memory, so it is reset with the rest.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            tx_out         <= 1'b1;
            fifo_rd_en_out <= 1'b0;
            busy_out       <= 1'b0;
            bytes_sent_out <= '0;
            shreg          <= '0;
            bit_idx        <= '0;
        end else begin
            tx_out         <= tx_d;
            fifo_rd_en_out <= rd_en_d;
            busy_out       <= busy_d;
            shreg          <= shreg_d;
            bit_idx        <= bit_idx_d;
            if (state == STOP && bit_done) begin
                bytes_sent_out <= bytes_sent_out + BYTES_CNT_W'(1);
            end
        end
    end

`ifdef FIFO_UART_TX_PARITY_EN
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            parity_q <= 1'b0;
        end else if (state == LATCH) begin
            parity_q <= ^fifo_data_in;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Randomized self-checking bench for fifo_uart_tx: a FIFO model feeds the DUT and
// a bit-centre UART receiver decodes the line against an expected-byte queue.
module tb_fifo_uart_tx;

    localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME_LEN = NBITS * CPB;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        fifo_empty;
    logic [7:0]  fifo_dout = 8'h00;
    logic        rd_en;
    logic        tx;
    logic        busy;
    logic [15:0] bytes_sent;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .enable_in      (enable),
        .fifo_empty_in  (fifo_empty),
        .fifo_data_in   (fifo_dout),
        .fifo_rd_en_out (rd_en),
        .tx_out         (tx),
        .busy_out       (busy),
        .bytes_sent_out (bytes_sent)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    // FIFO model: 1-cycle read latency, empty derived from push/pop counts
    logic [7:0] fifo_mem [0:255];
    int push_cnt   = 0;
    int pop_cnt    = 0;
    int rd_pulses  = 0;
    int underflows = 0;
    int cyc        = 0;

    assign fifo_empty = (push_cnt == pop_cnt);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_en === 1'b1) begin
            rd_pulses <= rd_pulses + 1;
            if (fifo_empty) underflows <= underflows + 1;
            else begin
                fifo_dout <= fifo_mem[pop_cnt[7:0]];
                pop_cnt   <= pop_cnt + 1;
            end
        end
    end

    // Receiver: samples each bit at its centre, records frame length and idle gap
    logic [NBITS-1:0] rx_bits [0:63];
    int rx_len [0:63];
    int rx_gap [0:63];
    int rx_cnt = 0;

    initial begin : monitor
        logic [NBITS-1:0] bits;
        int  len, start, prev_end;
        bit  aborted;
        prev_end = 0;
        forever begin
            @(posedge clk); #1;
            if (rst_n === 1'b1 && tx === 1'b0) begin
                start = cyc; bits = '0; len = 0; aborted = 0;
                for (int c = 0; c < FRAME_LEN + 8; c++) begin
                    if (c > 0) begin @(posedge clk); #1; end
                    if (rst_n !== 1'b1) begin aborted = 1; break; end
                    if (c % CPB == CPB / 2 && c / CPB < NBITS) bits[c / CPB] = tx;
                    if (busy === 1'b0) begin len = c; break; end
                end
                if (!aborted && rx_cnt < 64) begin
                    rx_bits[rx_cnt] = bits;
                    rx_len[rx_cnt]  = len;
                    rx_gap[rx_cnt]  = start - prev_end;
                    prev_end = start + len;
                    rx_cnt++;
                end
            end
        end
    end

    // Reference model
    logic [7:0] exp_q [$];
    int exp_sent = 0;
    int chk_idx  = 0;

    function automatic logic [NBITS-1:0] frame_bits(input logic [7:0] b);
`ifdef FIFO_UART_TX_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {1'b1, b, 1'b0};
`endif
    endfunction

    task automatic push(input logic [7:0] b);
        @(negedge clk);
        fifo_mem[push_cnt[7:0]] = b;
        push_cnt++;
        exp_q.push_back(b);
    endtask

    task automatic wait_frames(input int target, input int budget);
        for (int i = 0; i < budget && rx_cnt < target; i++) @(negedge clk);
        check("frames_done", rx_cnt, target);
    endtask

    task automatic wait_start();
        bit ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx === 1'b0) begin ok = 1; break; end
        end
        check("start_seen", ok, 1'b1);
    endtask

    task automatic check_new_frames();
        logic [7:0] b;
        while (chk_idx < rx_cnt) begin
            if (exp_q.size() == 0) begin
                check("unexpected_frame", chk_idx, rx_cnt);
                chk_idx = rx_cnt;
            end else begin
                b = exp_q.pop_front();
                check("frame_bits", rx_bits[chk_idx], frame_bits(b));
                check("frame_len", rx_len[chk_idx], FRAME_LEN);
                exp_sent = (exp_sent + 1) % 65536;
                chk_idx++;
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_sent = 0;
    endtask

    initial begin
        int base, pulses0;
        rst_n  = 1'b0;
        enable = 1'b1;

        // Reset held with a non-empty FIFO: no pop, idle outputs
        push(8'hA5);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_tx", tx, 1'b1);
            check("rst_busy", busy, 1'b0);
            check("rst_rd_en", rd_en, 1'b0);
            check("rst_bytes", bytes_sent, 16'd0);
        end
        check("rst_no_pop", rd_pulses, 0);

        // Single byte 0xA5
        rst_n = 1'b1;
        wait_frames(1, 200);
        check("a5_line", rx_bits[0][9:0], 10'b1_1010_0101_0);
        check_new_frames();
        @(negedge clk);
        check("a5_pulses", rd_pulses, 1);
        check("a5_sent", bytes_sent, exp_sent);
        check("a5_busy", busy, 1'b0);

        // Burst 1..16 queued before enabling
        enable = 1'b0;
        apply_reset();
        base = rx_cnt; pulses0 = rd_pulses;
        for (int i = 1; i <= 16; i++) push(8'(i));
        @(negedge clk);
        enable = 1'b1;
        wait_frames(base + 16, 16 * (FRAME_LEN + 10) + 100);
        check_new_frames();
        for (int i = base + 1; i < base + 16; i++) check("burst_gap", rx_gap[i], 3);
        @(negedge clk);
        check("burst_pulses", rd_pulses - pulses0, 16);
        check("burst_sent", bytes_sent, 16'd16);
        check("burst_underflow", underflows, 0);

        // enable dropped during data bit 4 of 0x3C with 2 bytes still queued
        enable = 1'b0;
        pulses0 = rd_pulses; base = rx_cnt;
        push(8'h3C); push(8'h11); push(8'h22);
        enable = 1'b1;
        wait_start();
        repeat (21) @(negedge clk);
        enable = 1'b0;
        wait_frames(base + 1, FRAME_LEN + 20);
        repeat (30) @(negedge clk);
        check_new_frames();
        check("en_drop_pulses", rd_pulses - pulses0, 1);
        check("en_drop_queued", push_cnt - pop_cnt, 2);
        check("en_drop_busy", busy, 1'b0);
        enable = 1'b1;
        wait_frames(base + 3, 2 * (FRAME_LEN + 10) + 50);
        check_new_frames();
        check("en_resume_sent", bytes_sent, exp_sent);

        // Reset pulsed during data bit 3: in-flight byte lost
        base = rx_cnt;
        push(8'h5A); push(8'h96);
        wait_start();
        repeat (17) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_tx", tx, 1'b1);
        check("midrst_sent", bytes_sent, 16'd0);
        check("midrst_busy", busy, 1'b0);
        void'(exp_q.pop_front());
        exp_sent = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_frames(base + 1, FRAME_LEN + 60);
        check_new_frames();
        check("midrst_after_sent", bytes_sent, exp_sent);

        // Random bytes pushed at random times while enabled
        base = rx_cnt;
        for (int i = 0; i < 10; i++) begin
            push(8'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 60)) @(negedge clk);
        end
        wait_frames(base + 10, 10 * (FRAME_LEN + 10) + 200);
        check_new_frames();
        @(negedge clk);
        check("rand_sent", bytes_sent, exp_sent);
        check("rand_drained", pop_cnt, push_cnt);
        check("rand_underflow", underflows, 0);

        // Parity-sensitive pair
        base = rx_cnt;
        push(8'h07); push(8'h03);
        wait_frames(base + 2, 2 * (FRAME_LEN + 10) + 50);
`ifdef FIFO_UART_TX_PARITY_EN
        check("parity_07", rx_bits[base][9], 1'b1);
        check("parity_03", rx_bits[base + 1][9], 1'b0);
`endif
        check_new_frames();
        check("final_sent", bytes_sent, exp_sent);
        check("final_expected_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Read-side consumer for the 8-bit byte FIFO (fifo_generator_0, standard mode, 1-cycle read latency).
- Pops one byte at a time while the FIFO is non-empty and the block is enabled.
- Serializes each byte onto a UART 8N1 line, LSB first.
- Drains the FIFO that upstream logic fills, e.g. debug/serial-link output from the Game Boy core to the host.

Parameters:
- CLKS_PER_BIT, 868: clock cycles per UART bit (100 MHz / 115200). Legal range is 2 or more.
- CNT_W, $clog2(CLKS_PER_BIT): width of the bit-timer counter. Derived; do not override.

Ports:
- clk_in  input  1  system clock; all logic on the rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- enable_in  input  1  1 = allowed to start new frames.
- fifo_empty_in  input  1  FIFO empty flag.
- fifo_data_in  input  8  FIFO dout; valid the cycle after rd_en.
- fifo_rd_en_out  output  1  FIFO rd_en; registered, 1-cycle pulse.
- tx_out  output  1  UART line; idles high.
- busy_out  output  1  1 while in any state other than IDLE.
- bytes_sent_out  output  16  count of completed frames; wraps.

Behaviour:
- Reset (rst_n_in=0, asynchronous): state=IDLE, tx_out=1, fifo_rd_en_out=0, busy_out=0, bytes_sent_out=0, shift register=0, bit timer=0.
- State machine: IDLE -> POP -> LATCH -> START -> DATA -> STOP -> IDLE.
- IDLE: if enable_in=1 and fifo_empty_in=0, go to POP. Otherwise stay; tx_out=1.
- POP: fifo_rd_en_out=1 for exactly this one cycle; next state LATCH.
  - A pop is never issued while fifo_empty_in=1, so the FIFO never underflows.
- LATCH: fifo_data_in is sampled on the rising edge that ends this cycle. On that same edge tx_out goes to 0 and the state goes to START.
- START: tx_out=0 for CLKS_PER_BIT cycles.
- DATA: bits 0..7 driven LSB first, each for CLKS_PER_BIT cycles. A 3-bit index counts bits; leave DATA after bit 7.
- STOP: tx_out=1 for CLKS_PER_BIT cycles. On the final cycle, bytes_sent_out increments (0xFFFF wraps to 0x0000) and the state goes to IDLE.
- Frame length: 10*CLKS_PER_BIT cycles from the start-bit edge to the end of the stop bit.
- Back-to-back frames: the IDLE/POP/LATCH cycles add 3 extra high cycles between frames. This gap is legal extra stop time.
- Bit timer: counts 0..CLKS_PER_BIT-1 and reloads to 0 at every bit boundary. There is no free-running baud tick, so jitter is 0.
- enable_in deasserted mid-frame: the current frame completes normally; no new POP. Also checked in IDLE only.
- fifo_empty_in rising during a frame: no effect; the byte is already latched.
- Reset mid-frame: tx_out returns to 1 asynchronously. The in-flight byte is lost (it was already popped), and the block restarts in IDLE.
- All outputs are registered; there are no combinational input-to-output paths.

Optional Feature:
- Macro: FIFO_UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - tx_out = XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles.
  - Frame becomes 11 bits (8E1).
- Undefined:
  - No PARITY state exists, and no parity logic is synthesized.
  - Frame is 8N1 as above.

Decomposition:
- Package uart_pkg:
  - typedef enum logic [2:0] tx_state_t {IDLE, POP, LATCH, START, DATA, PARITY, STOP}. PARITY is encoded even when unused.
  - localparam DATA_BITS=8.
  - localparam BYTES_CNT_W=16.
- Sub-module uart_bit_timer (param CLKS_PER_BIT):
  - Inputs: clk_in, rst_n_in, restart_in.
  - Output: bit_done_out, high on the last cycle of each bit period.
  - Instantiated once. The FSM pulses restart_in on entry to START.

Test Plan (CLKS_PER_BIT=4 unless stated; FIFO model with 1-cycle read latency):
- Reset: hold rst_n_in=0 for 5 cycles with fifo_empty_in=0 -> tx_out=1, fifo_rd_en_out=0, busy_out=0, bytes_sent_out=0 throughout; no pop.
- Single byte 0xA5 -> exactly one rd_en pulse. Line samples at bit centres give 0,1,0,1,0,0,1,0,1,1. Frame length is 40 cycles; bytes_sent_out=1; busy_out=0 afterwards.
- Enqueue 1..16, then enable_in=1 -> exactly 16 rd_en pulses, never while empty. The decoded stream is 1..16 in order. bytes_sent_out=16, and inter-frame high gap is 3 cycles.
- enable_in=0 during data bit 4 of byte 0x3C, with 2 bytes still queued -> 0x3C completes intact; no further rd_en. Re-enabling resumes with the next byte.
- rst_n_in pulsed low during data bit 3 -> tx_out=1 in the same timestep, and bytes_sent_out=0. After release, the next queued byte transmits cleanly.
- With FIFO_UART_TX_PARITY_EN defined, send 0x07 and then 0x03 -> parity bits are 1 and 0 respectively; frames are 44 cycles each.
